slave_port: RTL and testbench

SLAVE_PORT -- requirements
Module: slave_port

---
 rtl/slave_port_if.sv | 21 ++
 rtl/slave_port.sv | 161 ++++++++++++++++
 tb/tb_slave_port.sv | 248 ++++++++++++++++++++++++
 3 files changed

// File: rtl/slave_port_if.sv
// Serial arbiter-to-slave bus: bit-serial address/data in, bit-serial read data out.
interface slave_port_if;
   logic address;
   logic data;
   logic valid;
   logic write_en;
   logic bus_ready;
   logic data_out;
   logic ready;
   logic valid_out;

   modport master (
      output address, data, valid, write_en, bus_ready,
      input  data_out, ready, valid_out
   );

   modport slave (
      input  address, data, valid, write_en, bus_ready,
      output data_out, ready, valid_out
   );
endinterface

// File: rtl/slave_port.sv
// Serial-bus memory slave: shifts in address (and write data), writes or reads a local
// memory word, and shifts read data back out MSB first.
module slave_port #(
   parameter int unsigned ADDR_WIDTH = 12,
   parameter int unsigned DATA_WIDTH = 8,
   parameter int unsigned MEM_DEPTH  = 2**ADDR_WIDTH
) (
   input logic         clk,
   input logic         reset,
   slave_port_if.slave bus
);
   localparam int unsigned MAX_W = (ADDR_WIDTH > DATA_WIDTH) ? ADDR_WIDTH : DATA_WIDTH;
   localparam int unsigned CNT_W = $clog2(MAX_W + 1);

   localparam logic [CNT_W-1:0] ADDR_LAST = CNT_W'(ADDR_WIDTH - 1);
   localparam logic [CNT_W-1:0] DATA_LAST = CNT_W'(DATA_WIDTH - 1);

   localparam logic [2:0] IDLE  = 3'd0;
   localparam logic [2:0] ADDR  = 3'd1;
   localparam logic [2:0] WDATA = 3'd2;
   localparam logic [2:0] WRITE = 3'd3;
   localparam logic [2:0] RLOAD = 3'd4;
   localparam logic [2:0] RDATA = 3'd5;

   logic [2:0]            state_q, state_d;
   logic [CNT_W-1:0]      cnt_q, cnt_d;
   logic [ADDR_WIDTH-1:0] addr_q, addr_d;
   logic                  we_q, we_d;
   logic [DATA_WIDTH-1:0] wbuf_q, wbuf_d;
   logic [DATA_WIDTH-1:0] rbuf_q, rbuf_d;
   logic                  ready_q, ready_d;
   logic                  valid_out_q, valid_out_d;
   logic                  data_out_q, data_out_d;
   logic                  mem_we_c;

   logic [DATA_WIDTH-1:0] mem_q [MEM_DEPTH];

   // Next-state and datapath; outputs are derived from the next state so they
   // line up with the state register after each edge.
   always_comb begin
      state_d  = state_q;
      cnt_d    = cnt_q;
      addr_d   = addr_q;
      we_d     = we_q;
      wbuf_d   = wbuf_q;
      rbuf_d   = rbuf_q;
      mem_we_c = 1'b0;

      case (state_q)
         IDLE: begin
            if (bus.valid && bus.bus_ready) begin
               addr_d  = ADDR_WIDTH'(bus.address);
               we_d    = bus.write_en;
               cnt_d   = CNT_W'(1);
               state_d = ADDR;
            end
         end
         ADDR: begin
            if (!bus.bus_ready) begin
               state_d = IDLE;
               cnt_d   = '0;
               addr_d  = '0;
            end else if (bus.valid) begin
               addr_d = ADDR_WIDTH'({addr_q, bus.address});
               if (cnt_q == ADDR_LAST) begin
                  cnt_d   = '0;
                  state_d = we_q ? WDATA : RLOAD;
               end else begin
                  cnt_d = cnt_q + CNT_W'(1);
               end
            end
         end
         WDATA: begin
            if (!bus.bus_ready) begin
               state_d = IDLE;
               cnt_d   = '0;
               addr_d  = '0;
               wbuf_d  = '0;
            end else if (bus.valid) begin
               wbuf_d = DATA_WIDTH'({wbuf_q, bus.data});
               if (cnt_q == DATA_LAST) begin
                  cnt_d   = '0;
                  state_d = WRITE;
               end else begin
                  cnt_d = cnt_q + CNT_W'(1);
               end
            end
         end
         WRITE: begin
            // Committed once all data bits are in; bus_ready no longer matters.
            mem_we_c = 1'b1;
            state_d  = IDLE;
         end
         RLOAD: begin
            if (!bus.bus_ready) begin
               state_d = IDLE;
               addr_d  = '0;
            end else begin
               rbuf_d  = mem_q[addr_q];
               cnt_d   = '0;
               state_d = RDATA;
            end
         end
         RDATA: begin
            if (!bus.bus_ready) begin
               state_d = IDLE;
               cnt_d   = '0;
               rbuf_d  = '0;
            end else begin
               rbuf_d = rbuf_q << 1;
               if (cnt_q == DATA_LAST) begin
                  cnt_d   = '0;
                  state_d = IDLE;
               end else begin
                  cnt_d = cnt_q + CNT_W'(1);
               end
            end
         end
         default: state_d = IDLE;
      endcase

      ready_d     = (state_d == IDLE);
      valid_out_d = (state_d == RDATA);
      data_out_d  = valid_out_d & rbuf_d[DATA_WIDTH-1];
   end

   always_ff @(posedge clk) begin
      if (!reset) begin
         state_q     <= IDLE;
         cnt_q       <= '0;
         addr_q      <= '0;
         we_q        <= 1'b0;
         wbuf_q      <= '0;
         rbuf_q      <= '0;
         ready_q     <= 1'b1;
         valid_out_q <= 1'b0;
         data_out_q  <= 1'b0;
      end else begin
         state_q     <= state_d;
         cnt_q       <= cnt_d;
         addr_q      <= addr_d;
         we_q        <= we_d;
         wbuf_q      <= wbuf_d;
         rbuf_q      <= rbuf_d;
         ready_q     <= ready_d;
         valid_out_q <= valid_out_d;
         data_out_q  <= data_out_d;
      end
   end

   // Memory is never cleared; a reset edge suppresses a pending write.
   always_ff @(posedge clk) begin
      if (mem_we_c && reset) begin
         mem_q[addr_q] <= wbuf_q;
      end
   end

   assign bus.ready     = ready_q;
   assign bus.valid_out = valid_out_q;
   assign bus.data_out  = data_out_q;
endmodule

// File: tb/tb_slave_port.sv
// Randomized scoreboard bench for slave_port: transaction-level memory model,
// expected read bits queued with their due cycle and checked by a monitor.
module tb_slave_port;
   localparam int unsigned AW = 12;
   localparam int unsigned DW = 8;

   logic clk = 1'b0;
   logic reset;
   slave_port_if bif ();

   slave_port #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW), .MEM_DEPTH(1 << AW)) dut (
      .clk   (clk),
      .reset (reset),
      .bus   (bif)
   );

   always #5 clk = ~clk;

   int cyc = 0;
   always @(posedge clk) cyc <= cyc + 1;

   int errors = 0;
   int checks = 0;
   bit mon_en = 1'b0;
   int ready_bad;
   int stall_plan [AW+DW];

   typedef struct {
      logic b;
      int   at;
   } exp_t;
   exp_t sb_q [$];
   exp_t mon_e;

   logic [DW-1:0] mem_m [logic [AW-1:0]];

   task automatic check1(input string name, input logic got, input logic exp);
      checks++;
      if (got !== exp) begin
         errors++;
         $display("FAIL %s: got %b expected %b (cycle %0d)", name, got, exp, cyc);
      end
   endtask

   task automatic checkn(input string name, input int got, input int exp);
      checks++;
      if (got != exp) begin
         errors++;
         $display("FAIL %s: got %0d expected %0d (cycle %0d)", name, got, exp, cyc);
      end
   endtask

   // Monitor: every valid_out cycle consumes one expected bit and its due cycle.
   always @(negedge clk) begin
      if (mon_en) begin
         if (bif.valid_out === 1'b1) begin
            if (sb_q.size() == 0) begin
               checkn("unexpected_valid_out", 1, 0);
            end else begin
               mon_e = sb_q.pop_front();
               check1("rd_bit", bif.data_out, mon_e.b);
               checkn("rd_cycle", cyc, mon_e.at);
            end
         end else begin
            check1("data_out_idle", bif.data_out, 1'b0);
            if (sb_q.size() != 0 && sb_q[0].at <= cyc) begin
               checkn("missing_valid_out", cyc, sb_q[0].at);
               void'(sb_q.pop_front());
            end
         end
      end
   end

   task automatic drive(input logic v, input logic a, input logic d, input logic we, input logic br);
      bif.valid     = v;
      bif.address   = a;
      bif.data      = d;
      bif.write_en  = we;
      bif.bus_ready = br;
   endtask

   task automatic drive_noise();
      drive(1'($urandom), 1'($urandom), 1'($urandom), 1'($urandom), 1'b1);
   endtask

   task automatic tick_busy();
      @(negedge clk);
      if (bif.ready !== 1'b0) ready_bad++;
   endtask

   task automatic clear_stalls();
      for (int k = 0; k < int'(AW + DW); k++) stall_plan[k] = 0;
   endtask

   task automatic rand_stalls(input int pct);
      for (int k = 0; k < int'(AW + DW); k++)
         stall_plan[k] = (int'($urandom_range(99)) < pct) ? int'($urandom_range(3, 1)) : 0;
   endtask

   // kind 1 drops bus_ready for one cycle, kind 2 pulses reset low for one cycle.
   task automatic do_abort(input int kind);
      drive(1'($urandom), 1'($urandom), 1'($urandom), 1'($urandom), (kind == 1) ? 1'b0 : 1'b1);
      if (kind == 2) reset = 1'b0;
      @(negedge clk);
      reset = 1'b1;
      drive(1'b0, 1'b0, 1'b0, 1'b0, 1'b1);
   endtask

   // One bus transaction. abort_bit>0 aborts after that many bits were captured;
   // for reads rd_show<DW aborts after that many data bits were presented.
   task automatic xfer(input bit we, input logic [AW-1:0] a, input logic [DW-1:0] d,
                       input int abort_bit, input int rd_show, input int kind, input bit toggle);
      int nbits;
      int c;
      logic [AW+DW-1:0] bits;
      logic [DW-1:0] dx;
      nbits = int'(AW) + (we ? int'(DW) : 0);
      bits = {a, d};
      ready_bad = 0;
      check1("ready_idle", bif.ready, 1'b1);
      for (int k = 0; k < nbits; k++) begin
         if (k > 0) begin
            for (int s = 0; s < stall_plan[k]; s++) begin
               drive(1'b0, 1'($urandom), 1'($urandom), 1'($urandom), 1'b1);
               tick_busy();
            end
         end
         if (k > 0 && k == abort_bit) begin
            do_abort(kind);
            checkn("ready_busy", ready_bad, 0);
            check1("ready_after_abort", bif.ready, 1'b1);
            check1("valid_out_after_abort", bif.valid_out, 1'b0);
            return;
         end
         drive(1'b1,
               (k < int'(AW)) ? bits[AW+DW-1-k] : 1'($urandom),
               (k >= int'(AW)) ? bits[AW+DW-1-k] : 1'($urandom),
               (k == 0) ? we : (toggle ? ~we : 1'($urandom)),
               1'b1);
         tick_busy();
      end
      c = cyc;
      if (we) begin
         drive_noise();
         @(negedge clk);
         checkn("ready_busy", ready_bad, 0);
         check1("ready_after_write", bif.ready, 1'b1);
         mem_m[a] = d;
      end else begin
         dx = mem_m[a];
         for (int i = 0; i < rd_show; i++) sb_q.push_back('{b: dx[DW-1-i], at: c + 1 + i});
         for (int i = 0; i < rd_show; i++) begin
            drive_noise();
            tick_busy();
         end
         if (rd_show < int'(DW)) begin
            do_abort(kind);
         end else begin
            drive_noise();
            @(negedge clk);
         end
         checkn("ready_busy", ready_bad, 0);
         check1("ready_after_read", bif.ready, 1'b1);
         check1("valid_out_after_read", bif.valid_out, 1'b0);
      end
      drive(1'b0, 1'b0, 1'b0, 1'b0, 1'b1);
   endtask

   initial begin
      #2_000_000;
      $display("FAIL watchdog: simulation did not finish (cycle %0d)", cyc);
      $fatal(1, "watchdog");
   end

   initial begin
      logic [AW-1:0] pool [4];
      logic [AW-1:0] ra;
      logic [DW-1:0] rd;
      bit rw;
      int kind, ab, show;
      pool = '{12'h0FF, 12'hFFF, 12'h000, 12'h555};

      reset = 1'b0;
      drive(1'b0, 1'b0, 1'b0, 1'b0, 1'b1);
      repeat (3) @(negedge clk);
      check1("reset_ready", bif.ready, 1'b1);
      check1("reset_valid_out", bif.valid_out, 1'b0);
      check1("reset_data_out", bif.data_out, 1'b0);
      reset = 1'b1;
      mon_en = 1'b1;
      @(negedge clk);
      clear_stalls();

      // Basic write then read of the same word.
      xfer(1'b1, 12'h123, 8'hA5, 0, DW, 0, 1'b0);
      xfer(1'b0, 12'h123, 8'h00, 0, DW, 0, 1'b0);

      // Stalls: 3 cycles mid-address, 2 mid-data.
      stall_plan[4] = 3;
      stall_plan[AW + 3] = 2;
      xfer(1'b1, 12'h001, 8'h3C, 0, DW, 0, 1'b0);
      clear_stalls();
      xfer(1'b0, 12'h001, 8'h00, 0, DW, 0, 1'b0);

      // bus_ready drop after the 4th data bit leaves the old word intact.
      xfer(1'b1, 12'h200, 8'h5A, 0, DW, 0, 1'b0);
      xfer(1'b1, 12'h200, 8'hFF, AW + 4, DW, 1, 1'b0);
      xfer(1'b0, 12'h200, 8'h00, 0, DW, 0, 1'b0);

      // Reset mid-read, then a full re-read.
      xfer(1'b0, 12'h123, 8'h00, 0, 3, 2, 1'b0);
      xfer(1'b0, 12'h123, 8'h00, 0, DW, 0, 1'b0);

      // write_en flipped after the first address bit.
      xfer(1'b1, 12'hABC, 8'h77, 0, DW, 0, 1'b1);
      xfer(1'b0, 12'hABC, 8'h00, 0, DW, 0, 1'b1);

      // Aborts in RDATA, RLOAD, ADDR, and reset during WDATA.
      xfer(1'b0, 12'h123, 8'h00, 0, 5, 1, 1'b0);
      xfer(1'b0, 12'h001, 8'h00, 0, 0, 1, 1'b0);
      xfer(1'b1, 12'h001, 8'h99, 5, DW, 1, 1'b0);
      xfer(1'b1, 12'h001, 8'h00, AW + 2, DW, 2, 1'b0);
      xfer(1'b0, 12'h001, 8'h00, 0, DW, 0, 1'b0);

      for (int t = 0; t < 40; t++) begin
         ra = pool[$urandom_range(3)];
         rw = 1'($urandom);
         if (!mem_m.exists(ra)) rw = 1'b1;
         rd = DW'($urandom);
         rand_stalls(25);
         kind = 0;
         ab = 0;
         show = DW;
         if ($urandom_range(5) == 0) begin
            kind = 1 + int'($urandom_range(1));
            if (rw) ab = 1 + int'($urandom_range(AW + DW - 2));
            else if (1'($urandom)) ab = 1 + int'($urandom_range(AW - 2));
            else show = int'($urandom_range(DW - 1));
         end
         xfer(rw, ra, rd, ab, show, kind, 1'($urandom));
      end

      repeat (3) @(negedge clk);
      checkn("scoreboard_drained", sb_q.size(), 0);
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end
endmodule
